px_scan_ctrl: RTL and testbench
===============================

Name: px_scan_ctrl

Overview:
- Sequences the 16-pixel analog oscillator array for the I2C slave digital block.
- On a start command it walks the enabled pixels in ascending index order. For each pixel it releases that pixel's oscillator, waits a settle time, then counts oscillator rising edges over a programmable gate window.
- Each count is handed to the register/I2C side through a valid/ready handshake. drdy pulses when the scan completes.

Parameters:
- NPX, 16, number of pixel oscillators (index width is fixed at 4 bits).
- CNT_W, 16, edge-counter and result width.
- GATE_W, 16, gate-length field width.
- SETTLE_CYC, 4, clk cycles between oscillator release and gate open (min 3, covers the synchronizer).

Ports:
- clk  in  1  system clock; the single clock of the block.
- rst  in  1  synchronous, active-low reset.
- start  in  1  single-cycle scan request; honoured only in IDLE.
- abort  in  1  terminate scan; honoured in any non-IDLE state.
- px_mask  in  NPX  pixel enable mask; latched on accepted start.
- gate_len  in  GATE_W  gate window in clk cycles; latched on accepted start; 0 is treated as 1.
- clk_px  in  NPX  raw oscillator outputs, asynchronous to clk.
- stop_osc  out  5  [4] = global stop (1 = all oscillators halted); [3:0] = selected pixel index.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_cnt  out  CNT_W  edge count for res_addr.
- res_addr  out  4  pixel index of res_cnt.
- busy  out  1  high in every state except IDLE.
- drdy  out  1  one-cycle pulse on scan completion; not raised on abort.

Behaviour:
- Reset values (rst low at a clk edge): state IDLE, stop_osc=5'b1_0000, res_valid=0, res_cnt=0, res_addr=0, busy=0, drdy=0, counters cleared. Reset mid-scan aborts immediately; no drdy.
- Input sync: a 2-flop synchronizer per clk_px bit, plus a third flop for rising-edge detect. Only the selected pixel's edge pulse feeds the counter.
- FSM states: IDLE, SELECT, SETTLE, GATE, STORE, DONE.
  - IDLE: start=1 latches px_mask and gate_len. If the mask is nonzero, go to SELECT; if the mask is zero, go straight to DONE.
  - SELECT (1 cycle): picks the lowest set mask bit at or above the cursor, sets stop_osc={1'b0, idx}, clears that mask bit, clears the counter, goes to SETTLE.
  - SETTLE: lasts exactly SETTLE_CYC cycles with counting disabled, then goes to GATE.
  - GATE: lasts max(gate_len,1) cycles, counting edge pulses of pixel idx. The counter saturates at all-ones and does not wrap. Then goes to STORE with stop_osc[4]=1 (oscillator halted in the same cycle the state enters STORE).
  - STORE: res_valid=1, res_cnt=count, res_addr=idx; outputs stay stable while res_ready=0. On res_valid&&res_ready, res_valid drops next cycle. If the latched mask has remaining bits, go to SELECT; otherwise go to DONE. res_ready=1 already waiting yields a one-cycle STORE.
  - DONE (1 cycle): drdy=1, stop_osc=5'b1_0000, then IDLE.
- Abort takes priority over every transition. Next cycle: IDLE, stop_osc=5'b1_0000, res_valid=0, no drdy. Any result not yet accepted is discarded.
- start outside IDLE is ignored. start and abort together in IDLE: start wins (abort is only meaningful when busy).
- Per-pixel latency from SELECT to res_valid: 1 + SETTLE_CYC + max(gate_len,1) cycles.
- Edges occurring during SETTLE, or within 2 cycles after the gate closes, are not counted (documented measurement loss).

Decomposition:
- Shared package px_pkg holds:
  - state enum;
  - constants NPX, STOP_ALL=5'b1_0000, PX_IDX_W=4.
- One sub-module, px_edge_sync: a parameterized NPX-wide 2-flop synchronizer with rising-edge pulse output.
- Priority encoder (next enabled pixel) stays inline as a function.

Test Plan:
- Reset: hold rst=0 for 3 clk with start=1 -> stop_osc=5'b10000, busy=0, res_valid=0, drdy=0 throughout.
- Single pixel: mask=16'h0004, gate_len=100, clk_px[2] at clk/10, res_ready=1 -> stop_osc=5'b00010 during SETTLE/GATE; one result with res_addr=2, res_cnt=10±1; drdy pulses 1 cycle after the handshake; exactly 1+4+100 cycles from SELECT to res_valid.
- Multi-pixel ordering and backpressure: mask=16'h8101, res_ready held low 20 cycles per result -> results appear in order addr 0, 8, 15; res_cnt/res_addr stable while stalled; single drdy at end.
- Zero cases: mask=0 -> DONE next cycle, drdy pulse, no res_valid. gate_len=0 with mask=16'h0001 -> gate lasts 1 cycle.
- Saturation: CNT_W=4, gate_len=200, oscillator at clk/4 -> res_cnt=4'hF.
- Abort and start interaction: abort mid-GATE on the second of 3 pixels -> IDLE next cycle, stop_osc=5'b10000, no drdy, no further results. start while busy -> ignored, mask unchanged.

Source files
------------

// File: rtl/px_pkg.sv
// rtl/px_pkg.sv - shared types and constants for the pixel scan controller
package px_pkg;
  localparam int NPX = 16;
  localparam int PX_IDX_W = 4;
  localparam logic [4:0] STOP_ALL = 5'b1_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SETTLE,
    S_GATE,
    S_STORE,
    S_DONE
  } state_t;
endpackage

// File: rtl/px_edge_sync.sv
// rtl/px_edge_sync.sv - per-bit 2-flop synchronizer with rising-edge pulse
module px_edge_sync #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_rise
);
  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;
endmodule

// File: rtl/px_scan_ctrl.sv
// rtl/px_scan_ctrl.sv - walks enabled pixels, gates and counts oscillator edges
module px_scan_ctrl #(
  parameter int NPX        = px_pkg::NPX,
  parameter int CNT_W      = 16,
  parameter int GATE_W     = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [NPX-1:0]    px_mask,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [NPX-1:0]    clk_px,
  output logic [4:0]        stop_osc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_cnt,
  output logic [3:0]        res_addr,
  output logic              busy,
  output logic              drdy
);
  import px_pkg::*;

  state_t                r_state;
  state_t                w_next;
  logic [NPX-1:0]        r_mask;
  logic [GATE_W-1:0]     r_gate;
  logic [GATE_W-1:0]     r_timer;
  logic [PX_IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic [4:0]            r_stop_osc;
  logic [NPX-1:0]        w_rise;
  logic [PX_IDX_W-1:0]   w_sel_idx;
  logic [PX_IDX_W-1:0]   w_next_idx;

  // Served bits are cleared from r_mask, so the lowest remaining bit is the next pixel.
  function automatic logic [PX_IDX_W-1:0] first_set(input logic [NPX-1:0] m);
    first_set = '0;
    for (int i = NPX - 1; i >= 0; i--) begin
      if (m[i]) first_set = PX_IDX_W'(i);
    end
  endfunction

  px_edge_sync #(.W(NPX)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (clk_px),
    .o_rise  (w_rise)
  );

  assign w_sel_idx  = first_set(r_mask);
  assign w_next_idx = (r_state == S_SELECT) ? w_sel_idx : r_idx;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = (px_mask != '0) ? S_SELECT : S_DONE;
      S_SELECT: w_next = S_SETTLE;
      S_SETTLE: if (r_timer == '0) w_next = S_GATE;
      S_GATE:   if (r_timer == '0) w_next = S_STORE;
      S_STORE:  if (res_ready) w_next = (r_mask != '0) ? S_SELECT : S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mask     <= '0;
      r_gate     <= '0;
      r_timer    <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_stop_osc <= STOP_ALL;
    end else begin
      // Oscillator runs only while the next state is SETTLE or GATE; registered to stay glitch-free.
      r_stop_osc <= ((w_next == S_SETTLE) || (w_next == S_GATE)) ? {1'b0, w_next_idx} : STOP_ALL;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mask <= px_mask;
            r_gate <= (gate_len == '0) ? GATE_W'(1) : gate_len;
          end
        end
        S_SELECT: begin
          r_idx            <= w_sel_idx;
          r_mask[w_sel_idx] <= 1'b0;
          r_cnt            <= '0;
          r_timer          <= GATE_W'(SETTLE_CYC - 1);
        end
        S_SETTLE: begin
          r_timer <= (r_timer == '0) ? (r_gate - GATE_W'(1)) : (r_timer - GATE_W'(1));
        end
        S_GATE: begin
          if (r_timer != '0) r_timer <= r_timer - GATE_W'(1);
          if (w_rise[r_idx] && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign stop_osc  = r_stop_osc;
  assign res_valid = (r_state == S_STORE);
  assign res_cnt   = r_cnt;
  assign res_addr  = r_idx;
  assign busy      = (r_state != S_IDLE);
  assign drdy      = (r_state == S_DONE);
endmodule

// File: tb/tb_px_scan_ctrl.sv
// tb/tb_px_scan_ctrl.sv - randomized self-checking bench for px_scan_ctrl
module tb_px_scan_ctrl;
  localparam int SETTLE = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] px_mask;
  logic [15:0] gate_len;
  logic [15:0] clk_px;
  logic [4:0]  stop_osc;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_cnt;
  logic [3:0]  res_addr;
  logic        busy;
  logic        drdy;
  logic [4:0]  sat_stop;
  logic        sat_valid;
  logic [3:0]  sat_cnt;
  logic [3:0]  sat_addr;
  logic        sat_busy;
  logic        sat_drdy;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int spurious = 0;
  int per [16];

  px_scan_ctrl #(.NPX(16), .CNT_W(16), .GATE_W(16), .SETTLE_CYC(SETTLE)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .px_mask(px_mask),
    .gate_len(gate_len), .clk_px(clk_px), .stop_osc(stop_osc), .res_valid(res_valid),
    .res_ready(res_ready), .res_cnt(res_cnt), .res_addr(res_addr), .busy(busy), .drdy(drdy)
  );

  px_scan_ctrl #(.NPX(16), .CNT_W(4), .GATE_W(16), .SETTLE_CYC(SETTLE)) u_sat (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .px_mask(px_mask),
    .gate_len(gate_len), .clk_px(clk_px), .stop_osc(sat_stop), .res_valid(sat_valid),
    .res_ready(res_ready), .res_cnt(sat_cnt), .res_addr(sat_addr), .busy(sat_busy), .drdy(sat_drdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Each oscillator is a square wave of per[i] clk cycles, shifted off the clk edge.
  initial begin
    clk_px = '0;
    forever begin
      @(posedge clk);
      #3;
      for (int i = 0; i < 16; i++)
        clk_px[i] = (per[i] >= 2) && ((cyc % per[i]) < (per[i] / 2));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint clampv(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic scan(input logic [15:0] mask, input logic [15:0] gl, input int stall,
                      input int abort_px, input int abort_off);
    int exp_q[$];
    int g, t_sel, n_res, tmo, lo, hi, bad, exp_px;
    logic [15:0] a0, c0;
    bit done;
    g = (gl == 0) ? 1 : int'(gl);
    for (int i = 0; i < 16; i++) if (mask[i]) exp_q.push_back(i);
    res_ready = (stall == 0);
    @(negedge clk);
    px_mask = mask; gate_len = gl; start = 1'b1;
    @(negedge clk);
    start = 1'b0; px_mask = 16'($urandom); gate_len = 16'($urandom);
    t_sel = cyc;
    if (mask == 0) begin
      chk("zero_drdy", drdy, 1);
      chk("zero_valid", res_valid, 0);
      @(negedge clk);
      chk("zero_idle", busy, 0);
      return;
    end
    n_res = 0; done = 0; tmo = 0;
    while (!done && tmo < 5000) begin
      if (n_res == 0 && cyc == t_sel + 2) begin
        start = 1'b1; px_mask = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      if (exp_q.size() > 0 && cyc == t_sel + 1)
        chk("stop_settle", stop_osc, {1'b0, 4'(exp_q[0])});
      if (exp_q.size() > 0 && cyc == t_sel + SETTLE + g)
        chk("stop_gate_end", stop_osc, {1'b0, 4'(exp_q[0])});
      if (abort_px == n_res && cyc == t_sel + SETTLE + 1 + abort_off) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_stop", stop_osc, 5'h10);
        chk("abort_valid", res_valid, 0);
        bad = 0;
        repeat (200) begin
          @(negedge clk);
          if (res_valid || drdy || busy) bad++;
        end
        chk("abort_quiet", bad, 0);
        return;
      end
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_result", 1, 0);
          done = 1;
        end else begin
          exp_px = exp_q.pop_front();
          chk("latency", cyc - t_sel, 1 + SETTLE + g);
          chk("stop_halted", stop_osc[4], 1);
          chk("addr", res_addr, exp_px);
          lo = g / per[exp_px];
          hi = (g + per[exp_px] - 1) / per[exp_px];
          chk("cnt", res_cnt, clampv(res_cnt, lo, hi));
          chk("cnt_sat", sat_cnt, clampv(sat_cnt, (lo > 15) ? 15 : lo, (hi > 15) ? 15 : hi));
          a0 = 16'(res_addr); c0 = res_cnt; bad = 0;
          repeat (stall) begin
            @(negedge clk);
            if (!res_valid || 16'(res_addr) !== a0 || res_cnt !== c0) bad++;
          end
          if (stall > 0) begin
            chk("stall_stable", bad, 0);
            res_ready = 1'b1;
          end
          @(negedge clk);
          res_ready = (stall == 0);
          chk("valid_drop", res_valid, 0);
          n_res++;
          if (exp_q.size() == 0) begin
            chk("drdy", drdy, 1);
            @(negedge clk);
            chk("drdy_pulse", drdy, 0);
            chk("end_idle", busy, 0);
            done = 1;
          end else begin
            if (drdy) spurious++;
            t_sel = cyc;
          end
        end
      end else begin
        if (drdy) spurious++;
        @(negedge clk);
        tmo++;
      end
    end
    if (!done) chk("timeout", 0, 1);
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] m;
    rst = 1'b0; start = 1'b1; abort = 1'b0; res_ready = 1'b0;
    px_mask = 16'hFFFF; gate_len = 16'd5;
    for (int i = 0; i < 16; i++) per[i] = 10;
    repeat (3) begin
      @(negedge clk);
      chk("rst_stop", stop_osc, 5'h10);
      chk("rst_busy", busy, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_drdy", drdy, 0);
    end
    rst = 1'b1; start = 1'b0;
    @(negedge clk);

    scan(16'h0004, 16'd100, 0, -1, 0);

    for (int i = 0; i < 16; i++) per[i] = $urandom_range(2, 12);
    scan(16'h8101, 16'(20 + $urandom_range(0, 40)), 20, -1, 0);

    scan(16'h0000, 16'd10, 0, -1, 0);
    scan(16'h0001, 16'd0, 0, -1, 0);

    per[4] = 4;
    scan(16'h0010, 16'd200, 0, -1, 0);

    scan(16'h0222, 16'd80, 1, 1, 30);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 16; i++) per[i] = $urandom_range(2, 12);
      m = 16'($urandom) & 16'($urandom);
      scan(m, 16'($urandom_range(0, 40)), $urandom_range(0, 3), -1, 0);
    end

    chk("spurious_drdy", spurious, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
